// File: rtl/lvds_pkg.sv
// lvds_pkg -- shared definitions for the LVDS receive deframer.
//
// Word layout on the wire (MSB first):
//   [31:30] I sync (2'b10) | [29:17] I sample | [16] ctrl_i
//   [15:14] Q sync (2'b01) | [13:1]  Q sample | [0]  ctrl_q
// An all-zero word is an idle gap and carries no sample.

package lvds_pkg;

    localparam int WORD_W    = 32;
    localparam int FIELD_W   = 13;
    localparam int BIT_CNT_W = 5;

    localparam logic [1:0] I_SYNC = 2'b10;
    localparam logic [1:0] Q_SYNC = 2'b01;

    // Field bit positions within the 32-bit word
    localparam int I_SYNC_HI  = 31;
    localparam int I_SYNC_LO  = 30;
    localparam int I_HI       = 29;
    localparam int I_LO       = 17;
    localparam int CTRL_I_BIT = 16;
    localparam int Q_SYNC_HI  = 15;
    localparam int Q_SYNC_LO  = 14;
    localparam int Q_HI       = 13;
    localparam int Q_LO       = 1;
    localparam int CTRL_Q_BIT = 0;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lvds_state_e;

    // Packed view of a word; field order matches the bit positions above.
    typedef struct packed {
        logic [1:0]         i_sync;
        logic [FIELD_W-1:0] i;
        logic               ctrl_i;
        logic [1:0]         q_sync;
        logic [FIELD_W-1:0] q;
        logic               ctrl_q;
    } lvds_word_t;

    function automatic logic word_is_valid(input logic [WORD_W-1:0] w);
        return (w[I_SYNC_HI:I_SYNC_LO] == I_SYNC) &&
               (w[Q_SYNC_HI:Q_SYNC_LO] == Q_SYNC);
    endfunction

    function automatic logic word_is_gap(input logic [WORD_W-1:0] w);
        return (w == '0);
    endfunction

endpackage

// File: rtl/lvds_rx_word_align.sv
// lvds_rx_word_align -- serial-to-word alignment for the LVDS deframer.
//
// Shifts rx_bit into a 32-bit register on enabled cycles. In HUNT every
// enabled bit is a candidate word boundary; the first valid word locks the
// alignment. In LOCKED only every 32nd enabled bit is evaluated; gap words
// are dropped, bad words bump a miss counter that drops lock at LOSS_LIMIT.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   rx_bit, rx_en    serial data and its qualifier
//   word             the word including the bit shifted this cycle
//   word_strobe      word is valid and should be emitted on this edge
//   word_bad         word failed the check while locked (this edge)
//   locked           alignment established

module lvds_rx_word_align
    import lvds_pkg::*;
#(
    parameter int LOSS_LIMIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_bit,
    input  logic       rx_en,
    output lvds_word_t word,
    output logic       word_strobe,
    output logic       word_bad,
    output logic       locked
);

    localparam int MISS_W = (LOSS_LIMIT < 2) ? 1 : $clog2(LOSS_LIMIT + 1);

    logic [WORD_W-1:0]    sr_q, sr_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [MISS_W-1:0]    miss_q, miss_d;
    lvds_state_e          state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            miss_q    <= '0;
            state_q   <= HUNT;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            miss_q    <= miss_d;
            state_q   <= state_d;
        end
    end

    // Decisions look at sr_d so the word is judged on the same edge that
    // shifts in its bit 0; the top registers the fields on that edge.
    always_comb begin
        sr_d        = rx_en ? {sr_q[WORD_W-2:0], rx_bit} : sr_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        miss_d      = miss_q;
        word_strobe = 1'b0;
        word_bad    = 1'b0;

        if (rx_en) begin
            unique case (state_q)
                HUNT: begin
                    if (word_is_valid(sr_d)) begin
                        word_strobe = 1'b1;
                        state_d     = LOCKED;
                        bit_cnt_d   = '0;
                        miss_d      = '0;
                    end
                end
                LOCKED: begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // Boundary reached when the counter wraps 31 -> 0
                    if (bit_cnt_q == '1) begin
                        if (word_is_valid(sr_d)) begin
                            word_strobe = 1'b1;
                            miss_d      = '0;
                        end else if (word_is_gap(sr_d)) begin
                            miss_d = '0;
                        end else begin
                            word_bad = 1'b1;
                            if (int'(miss_q) + 1 >= LOSS_LIMIT) begin
                                state_d = HUNT;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign word   = lvds_word_t'(sr_d);
    assign locked = (state_q == LOCKED);

endmodule

// File: rtl/lvds_rx_deframer.sv
// lvds_rx_deframer -- LVDS I/Q word deframer with a one-deep output holder.
//
// Build option: define LVDS_RX_STATS_EN to include the saturating 16-bit
// sample/error statistics counters. Without it the counter ports read 0,
// stats_clr is ignored and no counter registers exist.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   rx_bit, rx_en                serial data (MSB first) and qualifier
//   sample_i/q, ctrl_i/q         held sample fields
//   sample_valid, sample_ready   hold handshake (emit overwrites on overflow)
//   locked                       word alignment established
//   sync_err                     one-cycle pulse per bad word while locked
//   overflow                     sticky: a held sample was overwritten
//   stats_clr                    clear statistics counters
//   sample_count, err_count      statistics counters

module lvds_rx_deframer
    import lvds_pkg::*;
#(
    parameter int SAMPLE_W   = 13,
    parameter int LOSS_LIMIT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_bit,
    input  logic                rx_en,
    output logic [SAMPLE_W-1:0] sample_i,
    output logic [SAMPLE_W-1:0] sample_q,
    output logic                ctrl_i,
    output logic                ctrl_q,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                locked,
    output logic                sync_err,
    output logic                overflow,
    input  logic                stats_clr,
    output logic [15:0]         sample_count,
    output logic [15:0]         err_count
);

    lvds_word_t word;
    logic       word_strobe;
    logic       word_bad;

    lvds_rx_word_align #(
        .LOSS_LIMIT (LOSS_LIMIT)
    ) u_align (
        .clk         (clk),
        .reset       (reset),
        .rx_bit      (rx_bit),
        .rx_en       (rx_en),
        .word        (word),
        .word_strobe (word_strobe),
        .word_bad    (word_bad),
        .locked      (locked)
    );

    // Sync fields were already checked inside the aligner.
    logic [3:0] sync_unused;
    assign sync_unused = {word.i_sync, word.q_sync};

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_i     <= '0;
            sample_q     <= '0;
            ctrl_i       <= 1'b0;
            ctrl_q       <= 1'b0;
            sample_valid <= 1'b0;
            sync_err     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            sync_err <= word_bad;
            if (word_strobe) begin
                sample_i     <= SAMPLE_W'(word.i);
                sample_q     <= SAMPLE_W'(word.q);
                ctrl_i       <= word.ctrl_i;
                ctrl_q       <= word.ctrl_q;
                sample_valid <= 1'b1;
                // Only a sample that is not being taken this cycle is lost
                if (sample_valid && !sample_ready)
                    overflow <= 1'b1;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

`ifdef LVDS_RX_STATS_EN
    logic [15:0] sample_cnt_q;
    logic [15:0] err_cnt_q;

    // Clear wins over a coincident increment; both saturate.
    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            if (word_strobe && sample_cnt_q != 16'hFFFF)
                sample_cnt_q <= sample_cnt_q + 16'd1;
            if (word_bad && err_cnt_q != 16'hFFFF)
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign sample_count = sample_cnt_q;
    assign err_count    = err_cnt_q;
`else
    logic stats_unused;
    assign stats_unused = stats_clr;
    assign sample_count = '0;
    assign err_count    = '0;
`endif

endmodule
